// File: rtl/uart_mmio_if.sv
// CPU data-port bundle between the MEM stage and the memory-mapped UART.
// The core drives the strobes, address and store word; the UART answers with sel and load_data.
interface uart_mmio_if #(
  parameter int XLEN = 32
);
  logic            mem_load;
  logic            mem_store;
  logic [XLEN-1:0] address;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] load_data;
  logic            sel;

  modport master (
    output mem_load, mem_store, address, store_data,
    input  load_data, sel
  );

  modport slave (
    input  mem_load, mem_store, address, store_data,
    output load_data, sel
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIV registers, a TX FIFO
// and a baud-timed serial FSM. Register reads return combinationally on load_data.
module uart_mmio #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter int              CLK_DIV    = 16,
  parameter int              FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  uart_mmio_if.slave  bus,
  output logic        txd
);

  localparam int          PTR_W   = $clog2(FIFO_DEPTH);
  localparam int          CNT_W   = PTR_W + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_DIV    = 2'd2,
    REG_RSVD   = 2'd3
  } reg_t;

  // ---------------------------------------------------------------------------
  // Address decode and access qualifiers
  // ---------------------------------------------------------------------------
  reg_t reg_idx;
  logic wr_en;
  logic rd_en;
  logic wr_txdata;
  logic wr_div;
  logic rd_status;

  assign bus.sel   = (bus.address[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign reg_idx   = reg_t'(bus.address[3:2]);
  assign wr_en     = bus.sel & bus.mem_store;
  assign rd_en     = bus.sel & bus.mem_load;
  assign wr_txdata = wr_en & (reg_idx == REG_TXDATA);
  assign wr_div    = wr_en & (reg_idx == REG_DIV);
  assign rd_status = rd_en & (reg_idx == REG_STATUS);

  // Byte lane bits and the upper store bits have no destination in this block.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.address[1:0], bus.store_data[XLEN-1:16]};

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  state_t state;
  state_t state_n;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = wr_txdata & ~full;
  assign pop   = (state == IDLE) & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, so clearing them is enough to discard queued bytes.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= bus.store_data[7:0];
  end

  // ---------------------------------------------------------------------------
  // DIV and sticky overflow
  // ---------------------------------------------------------------------------
  logic [15:0] div;
  logic        overflow;
  logic        ovf_set;

  assign ovf_set = wr_txdata & full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div      <= DIV_RST;
      overflow <= 1'b0;
    end else begin
      if (wr_div) div <= bus.store_data[15:0];
      // A drop on the same edge as a STATUS read keeps the flag set.
      overflow <= ovf_set | (overflow & ~rd_status);
    end
  end

  // ---------------------------------------------------------------------------
  // Serial FSM
  // ---------------------------------------------------------------------------
  logic [15:0] bc;
  logic [15:0] bc_n;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_n;
  logic [7:0]  shift;
  logic [7:0]  shift_n;
  logic        txd_n;
  logic        bit_end;

  // DIV is compared live, so lowering it mid-bit ends that bit on the next cycle.
  assign bit_end = (bc >= div);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bc      <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      bc      <= bc_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      txd     <= txd_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    bc_n      = bc;
    bit_idx_n = bit_idx;
    shift_n   = shift;

    unique case (state)
      IDLE: begin
        if (!empty) begin
          shift_n = fifo_mem[rd_ptr];
          bc_n    = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          bc_n      = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          bc_n = bc + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          bc_n      = '0;
          shift_n   = {1'b0, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          bc_n = bc + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          bc_n    = '0;
          state_n = IDLE;
        end else begin
          bc_n = bc + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // txd is registered from the next state so it lines up with the state register.
    unique case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic        busy;
  logic [31:0] status_word;

  assign busy        = (state != IDLE);
  assign status_word = {16'd0, 8'(count), 4'd0, overflow, empty, full, busy};

  always_comb begin
    bus.load_data = '0;
    if (bus.sel) begin
      unique case (reg_idx)
        REG_STATUS: bus.load_data = XLEN'(status_word);
        REG_DIV:    bus.load_data = XLEN'(div);
        default:    bus.load_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed self-checking bench for uart_mmio: register map, frame timing,
// back-to-back frames, live DIV change, FIFO overflow and mid-frame reset.
module tb_uart_mmio;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam logic [31:0] A_TX    = BASE + 32'h0;
  localparam logic [31:0] A_STAT  = BASE + 32'h4;
  localparam logic [31:0] A_DIV   = BASE + 32'h8;
  localparam logic [31:0] A_RSVD  = BASE + 32'hC;
  localparam logic [31:0] A_OUT   = BASE + 32'h20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic txd;

  int passed = 0;
  int total  = 0;

  uart_mmio_if #(.XLEN(32)) bus_if ();

  uart_mmio #(
    .XLEN       (32),
    .BASE_ADDR  (BASE),
    .CLK_DIV    (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if),
    .txd   (txd)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All bus tasks start and end just after a falling edge.
  task automatic bus_idle();
    bus_if.mem_load   = 1'b0;
    bus_if.mem_store  = 1'b0;
    bus_if.address    = '0;
    bus_if.store_data = '0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_if.mem_store  = 1'b1;
    bus_if.address    = addr;
    bus_if.store_data = data;
    @(negedge clock);
    bus_if.mem_store  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic s);
    bus_if.mem_load = 1'b1;
    bus_if.address  = addr;
    #1;
    data = bus_if.load_data;
    s    = bus_if.sel;
    @(negedge clock);
    bus_if.mem_load = 1'b0;
  endtask

  // Captures txd per bit cell while polling STATUS.busy every cycle.
  task automatic sample_frame(input int div, input int first_bit,
                              output logic [9:0] bits, output logic stable,
                              output logic busy_all);
    bits     = '0;
    stable   = 1'b1;
    busy_all = 1'b1;
    bus_if.mem_load = 1'b1;
    bus_if.address  = A_STAT;
    for (int i = first_bit; i < 10; i++) begin
      for (int c = 0; c <= div; c++) begin
        #1;
        if (c == 0) bits[i] = txd;
        else if (txd !== bits[i]) stable = 1'b0;
        if (bus_if.load_data[0] !== 1'b1) busy_all = 1'b0;
        @(negedge clock);
      end
    end
    bus_if.mem_load = 1'b0;
  endtask

  task automatic apply_reset();
    bus_idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        s;
    bus_idle();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd);
    else passed++;
    bus_read(A_STAT, rd, s);
    total++;
    if ({s, rd} !== {1'b1, 32'h0000_0004}) $display("FAIL reset_status: got sel=%b %h want sel=1 00000004", s, rd);
    else passed++;
    bus_read(A_TX, rd, s);
    total++;
    if (rd !== 32'h0) $display("FAIL reset_txdata_read: got %h want 00000000", rd);
    else passed++;
    bus_read(A_OUT, rd, s);
    total++;
    if ({s, rd} !== {1'b0, 32'h0}) $display("FAIL outside_window: got sel=%b %h want sel=0 00000000", s, rd);
    else passed++;
    bus_read(A_DIV, rd, s);
    total++;
    if (rd !== 32'h0000_000F) $display("FAIL reset_div: got %h want 0000000f", rd);
    else passed++;
    bus_read(A_RSVD, rd, s);
    total++;
    if (rd !== 32'h0) $display("FAIL reserved_read: got %h want 00000000", rd);
    else passed++;
  endtask

  task automatic test_frame();
    logic [31:0] rd;
    logic        s;
    logic [9:0]  bits;
    logic        stable;
    logic        busy_all;
    bus_write(A_DIV, 32'hABCD_0003);
    bus_read(A_DIV, rd, s);
    total++;
    if (rd !== 32'h0000_0003) $display("FAIL div_upper_ignored: got %h want 00000003", rd);
    else passed++;
    bus_write(A_TX, 32'h0000_01A5);
    #1;
    total++;
    if (txd !== 1'b1) $display("FAIL frame_latency_idle: got %b want 1", txd);
    else passed++;
    @(negedge clock);
    sample_frame(3, 0, bits, stable, busy_all);
    total++;
    if (bits !== 10'b1_1010_0101_0) $display("FAIL frame_a5_bits: got %b want 1101001010", bits);
    else passed++;
    total++;
    if ({stable, busy_all} !== 2'b11) $display("FAIL frame_a5_timing: got stable=%b busy=%b want 1 1", stable, busy_all);
    else passed++;
    bus_read(A_STAT, rd, s);
    total++;
    if (rd !== 32'h0000_0004) $display("FAIL frame_end_status: got %h want 00000004", rd);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        s;
    logic        t;
    logic [9:0]  bits;
    logic        stable;
    logic        busy_all;
    bus_write(A_DIV, 32'd1);
    bus_write(A_TX, 32'h00);
    bus_write(A_TX, 32'hFF);
    sample_frame(1, 0, bits, stable, busy_all);
    total++;
    if ({stable, busy_all, bits} !== {2'b11, 10'b1_0000_0000_0})
      $display("FAIL b2b_frame0: got stable=%b busy=%b bits=%b want 1 1 1000000000", stable, busy_all, bits);
    else passed++;
    #1;
    t = txd;
    bus_read(A_STAT, rd, s);
    total++;
    if ({t, rd} !== {1'b1, 32'h0000_0100}) $display("FAIL b2b_gap: got txd=%b status=%h want txd=1 status=00000100", t, rd);
    else passed++;
    sample_frame(1, 0, bits, stable, busy_all);
    total++;
    if ({stable, busy_all, bits} !== {2'b11, 10'b1_1111_1111_0})
      $display("FAIL b2b_frame1: got stable=%b busy=%b bits=%b want 1 1 1111111110", stable, busy_all, bits);
    else passed++;
    bus_read(A_STAT, rd, s);
    total++;
    if (rd !== 32'h0000_0004) $display("FAIL b2b_end_status: got %h want 00000004", rd);
    else passed++;
  endtask

  task automatic test_div_change();
    logic [31:0] rd;
    logic        s;
    logic        ok;
    logic [9:0]  bits;
    logic        stable;
    logic        busy_all;
    bus_write(A_DIV, 32'd15);
    bus_write(A_TX, 32'h0F);
    @(negedge clock);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (txd !== 1'b0) ok = 1'b0;
      @(negedge clock);
    end
    #1;
    if (txd !== 1'b0) ok = 1'b0;
    bus_write(A_DIV, 32'd1);
    #1;
    if (txd !== 1'b0) ok = 1'b0;
    @(negedge clock);
    total++;
    if (ok !== 1'b1) $display("FAIL div_change_start: got ok=%b want 1", ok);
    else passed++;
    sample_frame(1, 1, bits, stable, busy_all);
    total++;
    if ({stable, busy_all, bits[9:1]} !== {2'b11, 9'b1_0000_1111})
      $display("FAIL div_change_bits: got stable=%b busy=%b bits=%b want 1 1 100001111", stable, busy_all, bits[9:1]);
    else passed++;
    bus_read(A_DIV, rd, s);
    total++;
    if (rd !== 32'h0000_0001) $display("FAIL div_change_read: got %h want 00000001", rd);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic        s;
    bus_write(A_DIV, 32'h0000_FFFF);
    for (int i = 0; i < 9; i++) bus_write(A_TX, 32'(i + 8'h30));
    bus_read(A_STAT, rd, s);
    total++;
    if (rd !== 32'h0000_0803) $display("FAIL fifo_full_status: got %h want 00000803", rd);
    else passed++;
    bus_write(A_TX, 32'h99);
    bus_read(A_STAT, rd, s);
    total++;
    if (rd !== 32'h0000_080B) $display("FAIL overflow_set: got %h want 0000080b", rd);
    else passed++;
    bus_read(A_STAT, rd, s);
    total++;
    if (rd !== 32'h0000_0803) $display("FAIL overflow_clear: got %h want 00000803", rd);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    logic        s;
    logic        t1;
    logic        t2;
    logic        ok;
    apply_reset();
    bus_write(A_DIV, 32'd3);
    bus_write(A_TX, 32'h02);
    bus_write(A_TX, 32'h11);
    bus_write(A_TX, 32'h22);
    bus_write(A_TX, 32'h33);
    repeat (6) @(negedge clock);
    #1;
    t1 = txd;
    repeat (4) @(negedge clock);
    #1;
    t2 = txd;
    total++;
    if ({t1, t2} !== 2'b10) $display("FAIL pre_reset_data_bits: got %b%b want 10", t1, t2);
    else passed++;
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (txd !== 1'b1) $display("FAIL async_reset_txd: got %b want 1", txd);
    else passed++;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    bus_read(A_STAT, rd, s);
    total++;
    if (rd !== 32'h0000_0004) $display("FAIL post_reset_status: got %h want 00000004", rd);
    else passed++;
    bus_read(A_DIV, rd, s);
    total++;
    if (rd !== 32'h0000_000F) $display("FAIL post_reset_div: got %h want 0000000f", rd);
    else passed++;
    ok = 1'b1;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (txd !== 1'b1) ok = 1'b0;
      @(negedge clock);
    end
    total++;
    if (ok !== 1'b1) $display("FAIL post_reset_no_frame: got ok=%b want 1", ok);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_div_change();
    test_overflow();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
